// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed data memory with async clear and combinational read
//
// Purpose: DEPTH x 32-bit storage addressed by byte address A. The low two
// address bits are ignored. Writes happen on the rising clk edge. Reads are
// combinational. An active-high reset clears every word asynchronously.
//
// Ports:
//   clk   in   1     clock; every state change except reset happens on its rising edge
//   reset in   1     asynchronous active-high clear; blocks writes and forces RD to 0
//   WE    in   1     write enable, sampled on the rising clk edge
//   A     in   AW    byte address; word index is A[AW-1:2]
//   WD    in   32    write data (whole word only, no byte enables)
//   RD    out  32    read data: word[A>>2] when in range, else 0
module data_memory #(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WE,
  input  logic [AW-1:0] A,
  input  logic [31:0]   WD,
  output logic [31:0]   RD
);

  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIW = AW - 2;
  // DEPTH expressed at the word-index width so the range compare is width-matched.
  localparam logic [WIW-1:0] DEPTH_W = WIW'(DEPTH);

  logic [WIW-1:0] word_idx;
  logic [IW-1:0]  mem_idx;
  logic           in_range;
  logic [31:0]    mem_q [DEPTH];

  // Byte-lane bits play no part in word selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^A[1:0];

  assign word_idx = A[AW-1:2];
  // The full index takes part in the compare, so high address bits beyond
  // the array are rejected rather than aliased onto low words.
  assign in_range = (word_idx < DEPTH_W);
  assign mem_idx  = word_idx[IW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (WE && in_range) begin
      mem_q[mem_idx] <= WD;
    end
  end

  // Reset gating keeps RD at 0 for the whole reset pulse regardless of
  // when the cleared array values propagate. The old word is seen until
  // the write edge; there is no write-through path from WD.
  assign RD = (!reset && in_range) ? mem_q[mem_idx] : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory against an array model
module tb_data_memory;

  localparam int DEPTH = 64;
  localparam int AW    = 32;

  logic          clk;
  logic          reset;
  logic          WE;
  logic [AW-1:0] A;
  logic [31:0]   WD;
  logic [31:0]   RD;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Reference storage: plain array of words, indexed by byte address / 4.
  logic [31:0] model [DEPTH];

  data_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
    .RD    (RD)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    if (reset) return 32'h0;
    if ((addr >> 2) < DEPTH) return model[addr >> 2];
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s A=%0d got %h expected %h", name, A, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  // Drive inputs (called at posedge+2), let one edge pass, apply the write
  // rule to the model, and return at the next posedge+2.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd);
    WE = we;
    A  = a;
    WD = wd;
    @(posedge clk);
    if (!reset && we && ((a >> 2) < DEPTH)) model[a >> 2] = wd;
    #2;
  endtask

  initial begin
    reset = 1;
    WE = 0;
    A = '0;
    WD = '0;
    clear_model();

    fork
      forever begin
        @(negedge clk);
        if (cmp_en) check("rd_model", RD, model_rd(A));
      end
    join_none

    cmp_en = 1;
    repeat (2) @(posedge clk);
    #2;
    reset = 0;

    // Clear-after-reset sweep across the whole default range.
    for (int a = 0; a <= 252; a += 4) begin
      cycle(0, a, 32'hFFFF_FFFF);
      check("sweep_zero", RD, 32'h0);
    end

    // Two back-to-back writes, then readback including ignored low bits.
    cycle(1, 64, 45);
    cycle(1, 128, 100);
    cycle(0, 64, 0);
    check("rd_64", RD, 32'd45);
    cycle(0, 128, 0);
    check("rd_128", RD, 32'd100);
    cycle(0, 66, 0);
    check("rd_66_alias", RD, 32'd45);

    // WE=0 holds contents even with new data on WD.
    repeat (3) begin
      cycle(0, 64, 999);
      check("we0_hold", RD, 32'd45);
    end

    // Out-of-range write is dropped.
    cycle(1, 256, 7);
    check("oor_rd", RD, 32'h0);
    cycle(0, 64, 0);
    check("oor_no_alias", RD, 32'd45);
    cycle(0, 0, 0);
    check("oor_word0", RD, 32'h0);

    // Same-address write: old value before the edge, new value after.
    WE = 1;
    A  = 64;
    WD = 32'hDEAD_BEEF;
    #6;
    check("pre_edge_old", RD, 32'd45);
    @(posedge clk);
    model[16] = 32'hDEAD_BEEF;
    #1;
    check("post_edge_new", RD, 32'hDEAD_BEEF);
    #1;

    // Async reset between edges: RD drops with no clock edge.
    WE = 0;
    reset = 1;
    clear_model();
    #1;
    check("async_clear", RD, 32'h0);
    @(posedge clk);
    #2;
    reset = 0;
    cycle(0, 64, 0);
    check("rst_64", RD, 32'h0);
    cycle(0, 128, 0);
    check("rst_128", RD, 32'h0);

    // First edge after reset release already writes.
    cycle(1, 16, 77);
    check("first_write", RD, 32'd77);

    // Reset asserted during a write cycle wins.
    WE = 1;
    A  = 16;
    WD = 55;
    #1;
    reset = 1;
    clear_model();
    @(posedge clk);
    #2;
    reset = 0;
    cycle(0, 16, 0);
    check("rst_wins_write", RD, 32'h0);

    // Upper boundary of the range.
    cycle(1, 252, 32'h1234_5678);
    check("last_word", RD, 32'h1234_5678);
    cycle(0, 255, 0);
    check("last_word_hi", RD, 32'h1234_5678);
    cycle(1, 259, 32'hAAAA_5555);
    check("just_oor", RD, 32'h0);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        WE = 1'($urandom);
        reset = 1;
        clear_model();
        @(posedge clk);
        #2;
        reset = 0;
      end else begin
        logic [31:0] ra;
        case ($urandom_range(0, 7))
          0:       ra = $urandom;
          1:       ra = $urandom_range(240, 270);
          default: ra = $urandom_range(0, 255);
        endcase
        cycle(1'($urandom_range(0, 1)), ra, $urandom);
      end
    end

    // Final readback of every word against the model.
    for (int a = 0; a < DEPTH * 4; a += 4) begin
      cycle(0, a, 0);
      check("final_sweep", RD, model[a >> 2]);
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
